// File: rtl/lsu_unit.sv
// Load/store unit: one data-memory transaction per request over a req/ack handshake,
// with lane steering for stores, extension for loads, and fault/timeout reporting.
module lsu_unit #(
  parameter int unsigned WORD_SIZE      = 32,
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 req_valid,
  output logic                 req_ready,
  input  logic                 is_store,
  input  logic [2:0]           funct3,
  input  logic [WORD_SIZE-1:0] addr,
  input  logic [WORD_SIZE-1:0] store_data,
  input  logic [4:0]           rd,
  output logic                 mem_req,
  output logic                 mem_we,
  output logic [WORD_SIZE-1:0] mem_addr,
  output logic [3:0]           mem_wstrb,
  output logic [WORD_SIZE-1:0] mem_wdata,
  input  logic                 mem_ack,
  input  logic [WORD_SIZE-1:0] mem_rdata,
  output logic                 done,
  output logic                 wb_valid,
  output logic [4:0]           wb_rd,
  output logic [WORD_SIZE-1:0] wb_data,
  output logic                 exc_valid,
  output logic [1:0]           exc_cause,
  output logic [WORD_SIZE-1:0] exc_addr
);

  typedef enum logic [1:0] {StIdle, StReq, StDone} state_e;

  localparam logic [7:0] TimeoutLast = 8'(TIMEOUT_CYCLES - 1);

  state_e               state_q, state_d;
  logic                 is_store_q;
  logic [2:0]           funct3_q;
  logic [WORD_SIZE-1:0] addr_q;
  logic [4:0]           rd_q;
  logic [WORD_SIZE-1:0] mem_addr_q;
  logic [3:0]           wstrb_q;
  logic [WORD_SIZE-1:0] wdata_q;
  logic [7:0]           cnt_q, cnt_d;
  logic                 wb_valid_q, wb_valid_d;
  logic [WORD_SIZE-1:0] wb_data_q, wb_data_d;
  logic                 exc_valid_q, exc_valid_d;
  logic [1:0]           exc_cause_q, exc_cause_d;
  logic                 accept;

  logic                 legal_f3;
  logic                 misaligned;
  logic [3:0]           lane_strb;
  logic [WORD_SIZE-1:0] lane_wdata;
  logic [WORD_SIZE-1:0] shifted;
  logic [WORD_SIZE-1:0] load_ext;

  // Decode of the incoming request, evaluated only on accept.
  always_comb begin
    legal_f3 = 1'b0;
    case (funct3)
      3'b000, 3'b001, 3'b010: legal_f3 = 1'b1;
      3'b100, 3'b101:         legal_f3 = ~is_store;
      default:                legal_f3 = 1'b0;
    endcase

    misaligned = ((funct3[1:0] == 2'b01) && addr[0]) ||
                 ((funct3[1:0] == 2'b10) && (addr[1:0] != 2'b00));

    lane_strb  = 4'b1111;
    lane_wdata = store_data;
    case (funct3[1:0])
      2'b00: begin
        lane_strb  = 4'b0001 << addr[1:0];
        lane_wdata = {4{store_data[7:0]}};
      end
      2'b01: begin
        lane_strb  = 4'b0011 << addr[1:0];
        lane_wdata = {2{store_data[15:0]}};
      end
      default: begin
        lane_strb  = 4'b1111;
        lane_wdata = store_data;
      end
    endcase
    if (!is_store) begin
      lane_strb = 4'b0000;
    end
  end

  // Load extraction from the returned word using the latched request.
  always_comb begin
    shifted  = mem_rdata >> {addr_q[1:0], 3'b000};
    load_ext = shifted;
    case (funct3_q[1:0])
      2'b00:   load_ext = {{24{~funct3_q[2] & shifted[7]}}, shifted[7:0]};
      2'b01:   load_ext = {{16{~funct3_q[2] & shifted[15]}}, shifted[15:0]};
      default: load_ext = shifted;
    endcase
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    accept      = 1'b0;
    wb_valid_d  = 1'b0;
    wb_data_d   = wb_data_q;
    exc_valid_d = 1'b0;
    exc_cause_d = exc_cause_q;
    unique case (state_q)
      StIdle: begin
        if (req_valid) begin
          accept = 1'b1;
          cnt_d  = 8'd0;
          if (!legal_f3) begin
            state_d     = StDone;
            exc_valid_d = 1'b1;
            exc_cause_d = 2'd2;
          end else if (misaligned) begin
            state_d     = StDone;
            exc_valid_d = 1'b1;
            exc_cause_d = {1'b0, is_store};
          end else begin
            state_d = StReq;
          end
        end
      end
      StReq: begin
        // An ack in the last allowed cycle still completes the access.
        if (mem_ack) begin
          state_d    = StDone;
          wb_valid_d = ~is_store_q && (rd_q != 5'd0);
          if (!is_store_q) begin
            wb_data_d = load_ext;
          end
        end else if (cnt_q == TimeoutLast) begin
          state_d     = StDone;
          exc_valid_d = 1'b1;
          exc_cause_d = 2'd3;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= StIdle;
      is_store_q  <= 1'b0;
      funct3_q    <= 3'b000;
      addr_q      <= '0;
      rd_q        <= 5'd0;
      mem_addr_q  <= '0;
      wstrb_q     <= 4'b0000;
      wdata_q     <= '0;
      cnt_q       <= 8'd0;
      wb_valid_q  <= 1'b0;
      wb_data_q   <= '0;
      exc_valid_q <= 1'b0;
      exc_cause_q <= 2'd0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      wb_valid_q  <= wb_valid_d;
      wb_data_q   <= wb_data_d;
      exc_valid_q <= exc_valid_d;
      exc_cause_q <= exc_cause_d;
      if (accept) begin
        is_store_q <= is_store;
        funct3_q   <= funct3;
        addr_q     <= addr;
        rd_q       <= rd;
        mem_addr_q <= {addr[WORD_SIZE-1:2], 2'b00};
        wstrb_q    <= lane_strb;
        wdata_q    <= lane_wdata;
      end
    end
  end

  assign req_ready = (state_q == StIdle);
  assign mem_req   = (state_q == StReq);
  assign mem_we    = (state_q == StReq) && is_store_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wstrb = wstrb_q;
  assign mem_wdata = wdata_q;
  assign done      = (state_q == StDone);
  assign wb_valid  = wb_valid_q;
  assign wb_rd     = rd_q;
  assign wb_data   = wb_data_q;
  assign exc_valid = exc_valid_q;
  assign exc_cause = exc_cause_q;
  assign exc_addr  = addr_q;

endmodule

// File: tb/tb_lsu_unit.sv
// Self-checking bench for lsu_unit: directed plan cases plus randomized transactions
// checked against an arithmetic model of the load/store rules.
module tb_lsu_unit;

  localparam int unsigned Timeout = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid;
  logic        req_ready;
  logic        is_store;
  logic [2:0]  funct3;
  logic [31:0] addr;
  logic [31:0] store_data;
  logic [4:0]  rd;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [3:0]  mem_wstrb;
  logic [31:0] mem_wdata;
  logic        mem_ack;
  logic [31:0] mem_rdata;
  logic        done;
  logic        wb_valid;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;
  logic        exc_valid;
  logic [1:0]  exc_cause;
  logic [31:0] exc_addr;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  lsu_unit #(
    .WORD_SIZE      (32),
    .TIMEOUT_CYCLES (Timeout)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .is_store   (is_store),
    .funct3     (funct3),
    .addr       (addr),
    .store_data (store_data),
    .rd         (rd),
    .mem_req    (mem_req),
    .mem_we     (mem_we),
    .mem_addr   (mem_addr),
    .mem_wstrb  (mem_wstrb),
    .mem_wdata  (mem_wdata),
    .mem_ack    (mem_ack),
    .mem_rdata  (mem_rdata),
    .done       (done),
    .wb_valid   (wb_valid),
    .wb_rd      (wb_rd),
    .wb_data    (wb_data),
    .exc_valid  (exc_valid),
    .exc_cause  (exc_cause),
    .exc_addr   (exc_addr)
  );

  // Reference rules: access size n bytes at offset o, from arithmetic not lane tables.
  function automatic void model(input logic st, input logic [2:0] f3, input logic [31:0] a,
                                input logic [31:0] sd, input logic [31:0] rdat,
                                output logic fault, output logic [1:0] cause,
                                output logic [3:0] strb, output logic [31:0] wdat,
                                output logic [31:0] ld);
    int n;
    int o;
    logic legal;
    logic [63:0] v;
    logic [63:0] mask;
    o = int'(a[1:0]);
    legal = st ? (f3 inside {3'd0, 3'd1, 3'd2}) : (f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5});
    n = 1 << f3[1:0];
    fault = 1'b0;
    cause = 2'd0;
    strb  = 4'd0;
    wdat  = 32'd0;
    ld    = 32'd0;
    if (!legal) begin
      fault = 1'b1;
      cause = 2'd2;
    end else if ((o % n) != 0) begin
      fault = 1'b1;
      cause = st ? 2'd1 : 2'd0;
    end
    if (!fault && st) begin
      for (int i = 0; i < 4; i++) begin
        strb[i] = (i >= o) && (i < o + n);
        wdat[8*i +: 8] = sd[8*(i % n) +: 8];
      end
    end
    if (!fault && !st) begin
      mask = (64'd1 << (8 * n)) - 64'd1;
      v = ({32'd0, rdat} >> (8 * o)) & mask;
      if (!f3[2] && v[8*n-1]) v = v | ~mask;
      ld = v[31:0];
    end
  endfunction

  // Entry and exit: 1 time unit after a rising edge, DUT in IDLE. waits >= Timeout times out.
  task automatic run_txn(input logic st, input logic [2:0] f3, input logic [31:0] a,
                         input logic [31:0] sd, input logic [4:0] r, input int waits,
                         input logic [31:0] rdat, input string name);
    logic fault;
    logic [1:0] cause;
    logic [3:0] strb;
    logic [31:0] wdat;
    logic [31:0] ld;
    logic timed;
    logic exp_wbv;
    int ncyc;
    model(st, f3, a, sd, rdat, fault, cause, strb, wdat, ld);
    timed = !fault && (waits >= int'(Timeout));
    total++;
    if (req_ready !== 1'b1) begin
      bad++;
      $display("FAIL %s ready_idle: got %b want 1", name, req_ready);
    end
    is_store = st; funct3 = f3; addr = a; store_data = sd; rd = r; req_valid = 1'b1;
    @(posedge clk); #1;
    req_valid = 1'b0;
    is_store = 1'($urandom); addr = $urandom; store_data = $urandom; funct3 = 3'($urandom);
    if (fault) begin
      total++;
      if ({mem_req, done, exc_valid, exc_cause, exc_addr, wb_valid} !==
          {1'b0, 1'b1, 1'b1, cause, a, 1'b0}) begin
        bad++;
        $display("FAIL %s fault: got req=%b done=%b exc=%b cause=%0d addr=%h wbv=%b want cause=%0d addr=%h",
                 name, mem_req, done, exc_valid, exc_cause, exc_addr, wb_valid, cause, a);
      end
    end else begin
      ncyc = timed ? int'(Timeout) : waits + 1;
      for (int k = 0; k < ncyc; k++) begin
        total++;
        if ({req_ready, mem_req, mem_we, mem_addr, mem_wstrb, done} !==
            {1'b0, 1'b1, st, {a[31:2], 2'b00}, strb, 1'b0}) begin
          bad++;
          $display("FAIL %s req_cyc%0d: got rdy=%b req=%b we=%b addr=%h strb=%b done=%b want we=%b addr=%h strb=%b",
                   name, k, req_ready, mem_req, mem_we, mem_addr, mem_wstrb, done,
                   st, {a[31:2], 2'b00}, strb);
        end
        if (st) begin
          total++;
          if (mem_wdata !== wdat) begin
            bad++;
            $display("FAIL %s wdata_cyc%0d: got %h want %h", name, k, mem_wdata, wdat);
          end
        end
        if (!timed && k == waits) begin
          mem_ack = 1'b1;
          mem_rdata = rdat;
        end else begin
          mem_rdata = $urandom;
        end
        @(posedge clk); #1;
        mem_ack = 1'b0;
      end
      exp_wbv = !st && !timed && (r != 5'd0);
      total++;
      if ({mem_req, done, exc_valid, wb_valid} !== {1'b0, 1'b1, timed, exp_wbv}) begin
        bad++;
        $display("FAIL %s done: got req=%b done=%b exc=%b wbv=%b want 0 1 %b %b",
                 name, mem_req, done, exc_valid, wb_valid, timed, exp_wbv);
      end
      if (timed) begin
        total++;
        if ({exc_cause, exc_addr} !== {2'd3, a}) begin
          bad++;
          $display("FAIL %s timeout: got cause=%0d addr=%h want 3 %h", name, exc_cause, exc_addr, a);
        end
      end else if (!st) begin
        total++;
        if (wb_data !== ld || (exp_wbv && wb_rd !== r)) begin
          bad++;
          $display("FAIL %s load: got data=%h rd=%0d want data=%h rd=%0d", name, wb_data, wb_rd, ld, r);
        end
      end
    end
    @(posedge clk); #1;
    total++;
    if ({done, wb_valid, exc_valid, req_ready, mem_req} !== 5'b00010) begin
      bad++;
      $display("FAIL %s retire: got done=%b wbv=%b exc=%b rdy=%b req=%b want 0 0 0 1 0",
               name, done, wb_valid, exc_valid, req_ready, mem_req);
    end
    if (!fault && !timed && !st) begin
      total++;
      if (wb_data !== ld) begin
        bad++;
        $display("FAIL %s wb_hold: got %h want %h", name, wb_data, ld);
      end
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;
    @(posedge clk); #1;
    total++;
    if ({req_ready, mem_req, mem_we, done, wb_valid, exc_valid, mem_addr, mem_wstrb, mem_wdata,
         wb_rd, wb_data, exc_cause, exc_addr} !== {1'b1, 5'b0, 32'd0, 4'd0, 32'd0, 5'd0,
                                                    32'd0, 2'd0, 32'd0}) begin
      bad++;
      $display("FAIL reset_values: got rdy=%b req=%b done=%b addr=%h strb=%b wdata=%h wbd=%h exc_addr=%h",
               req_ready, mem_req, done, mem_addr, mem_wstrb, mem_wdata, wb_data, exc_addr);
    end
  endtask

  task automatic test_loads();
    run_txn(1'b0, 3'b010, 32'h100, 32'd0, 5'd5, 0, 32'hDEADBEEF, "lw");
    total++;
    if (wb_data !== 32'hDEADBEEF) begin
      bad++;
      $display("FAIL lw_value: got %h want deadbeef", wb_data);
    end
    run_txn(1'b0, 3'b000, 32'h103, 32'd0, 5'd7, 1, 32'h80FF7F01, "lb");
    total++;
    if (wb_data !== 32'hFFFFFF80) begin
      bad++;
      $display("FAIL lb_value: got %h want ffffff80", wb_data);
    end
    run_txn(1'b0, 3'b100, 32'h103, 32'd0, 5'd7, 0, 32'h80FF7F01, "lbu");
    total++;
    if (wb_data !== 32'h00000080) begin
      bad++;
      $display("FAIL lbu_value: got %h want 00000080", wb_data);
    end
    run_txn(1'b0, 3'b001, 32'h102, 32'd0, 5'd0, 2, 32'h8001_1234, "lh_rd0");
  endtask

  task automatic test_store();
    run_txn(1'b1, 3'b000, 32'h202, 32'h000000AB, 5'd3, 3, 32'd0, "sb");
    run_txn(1'b1, 3'b001, 32'h306, 32'h1234CDEF, 5'd3, 0, 32'd0, "sh");
    run_txn(1'b1, 3'b010, 32'h400, 32'hCAFEF00D, 5'd3, 1, 32'd0, "sw");
  endtask

  task automatic test_faults();
    run_txn(1'b0, 3'b001, 32'h101, 32'd0, 5'd4, 0, 32'd0, "lh_misaligned");
    run_txn(1'b1, 3'b011, 32'h200, 32'd0, 5'd4, 0, 32'd0, "store_f3_011");
    run_txn(1'b1, 3'b010, 32'h202, 32'd0, 5'd4, 0, 32'd0, "sw_misaligned");
    run_txn(1'b0, 3'b110, 32'h201, 32'd0, 5'd4, 0, 32'd0, "illegal_over_misalign");
  endtask

  task automatic test_timeout();
    run_txn(1'b0, 3'b010, 32'h500, 32'd0, 5'd9, 10, 32'd0, "timeout");
    mem_ack = 1'b1;
    mem_rdata = 32'h5555AAAA;
    @(posedge clk); #1;
    mem_ack = 1'b0;
    total++;
    if ({done, wb_valid, mem_req} !== 3'b000) begin
      bad++;
      $display("FAIL late_ack: got done=%b wbv=%b req=%b want 0 0 0", done, wb_valid, mem_req);
    end
    run_txn(1'b0, 3'b010, 32'h504, 32'd0, 5'd9, int'(Timeout) - 1, 32'h13579BDF, "ack_last_cycle");
  endtask

  task automatic test_reset_in_req();
    is_store = 1'b0; funct3 = 3'b010; addr = 32'h600; rd = 5'd6; req_valid = 1'b1;
    @(posedge clk); #1;
    req_valid = 1'b0;
    @(posedge clk); #1;
    total++;
    if (mem_req !== 1'b1) begin
      bad++;
      $display("FAIL rst_req_pre: got mem_req=%b want 1", mem_req);
    end
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    total++;
    if ({mem_req, req_ready} !== 2'b01) begin
      bad++;
      $display("FAIL rst_req_drop: got req=%b rdy=%b want 0 1", mem_req, req_ready);
    end
    mem_ack = 1'b1;
    mem_rdata = 32'h0BADF00D;
    @(posedge clk); #1;
    mem_ack = 1'b0;
    total++;
    if ({done, wb_valid, exc_valid} !== 3'b000) begin
      bad++;
      $display("FAIL rst_req_ack: got done=%b wbv=%b exc=%b want 0 0 0", done, wb_valid, exc_valid);
    end
  endtask

  task automatic test_random();
    logic st;
    logic [2:0] f3;
    logic [31:0] a;
    for (int i = 0; i < 60; i++) begin
      st = 1'($urandom);
      f3 = (i % 4 == 0) ? 3'($urandom) :
           (st ? 3'($urandom_range(0, 2)) : 3'(($urandom_range(0, 4) + 3) % 8 == 6 ? 4 : $urandom_range(0, 2)));
      a = $urandom;
      if (i % 3 == 0) a[1:0] = 2'b00;
      run_txn(st, f3, a, $urandom, 5'($urandom_range(0, 31)), $urandom_range(0, 5), $urandom,
              "random");
    end
  endtask

  initial begin
    reset = 1'b1; req_valid = 1'b0; is_store = 1'b0; funct3 = 3'b000;
    addr = 32'd0; store_data = 32'd0; rd = 5'd0; mem_ack = 1'b0; mem_rdata = 32'd0;
    test_reset();
    test_loads();
    test_store();
    test_faults();
    test_timeout();
    test_reset_in_req();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/lsu_unit.md
# lsu_unit

Load/store unit directly downstream of the ALU in the single-issue RISC-V datapath. Takes the ALU result as effective address together with rs2 store data and funct3. Runs one data-memory transaction per request through a req/ack handshake, and returns sign- or zero-extended load data to writeback. Flags misaligned, illegal or timed-out accesses instead of issuing them to memory.

## Interface
- `WORD_SIZE`, default 32: datapath width. Only 32 is supported.
- `TIMEOUT_CYCLES`, default 255: maximum cycles `mem_req` is held without `mem_ack` before the access aborts. Range 1..255.

Ports:
- `clk`  in  1  clock; all state updates on posedge.
- `reset`  in  1  reset, synchronous, active-high.
- `req_valid`  in  1  request present this cycle.
- `req_ready`  out  1  high only in IDLE. Request accepted when `req_valid & req_ready`.
- `is_store`  in  1  1 = store, 0 = load.
- `funct3`  in  3  RISC-V size/sign code.
- `addr`  in  32  effective address (ALU `out`).
- `store_data`  in  32  rs2 value.
- `rd`  in  5  load destination register.
- `mem_req`  out  1  memory request, held until ack.
- `mem_we`  out  1  write enable.
- `mem_addr`  out  32  word-aligned address: {addr[31:2],2'b00}.
- `mem_wstrb`  out  4  byte-lane enables.
- `mem_wdata`  out  32  lane-replicated store data.
- `mem_ack`  in  1  memory completes the access this cycle.
- `mem_rdata`  in  32  read word, valid when `mem_ack`.
- `done`  out  1  one-cycle pulse, request retired (success or fault).
- `wb_valid`  out  1  one-cycle pulse, load data valid, rd != 0.
- `wb_rd`  out  5  destination register.
- `wb_data`  out  32  extended load data.
- `exc_valid`  out  1  one-cycle pulse with `done` on a fault.
- `exc_cause`  out  2  0 load misaligned, 1 store misaligned, 2 illegal funct3, 3 bus timeout.
- `exc_addr`  out  32  faulting effective address.

## Operation
- States: IDLE, REQ, DONE.
- IDLE: on accept, latch all request fields.
  - Legal and aligned: go to REQ.
  - Otherwise: go to DONE with the fault recorded. No memory access is issued.
- Legal funct3:
  - Loads: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU.
  - Stores: 000 SB, 001 SH, 010 SW.
  - Anything else is cause 2.
- Alignment: a halfword requires addr[0]=0; a word requires addr[1:0]=0. Violations are cause 0 (load) or cause 1 (store). Illegal funct3 takes priority over misalignment.
- REQ: `mem_req`=1 and `mem_we`=is_store. `mem_addr`, `mem_wstrb` and `mem_wdata` stay stable for the whole state.
  - On `mem_ack`: capture `mem_rdata` and go to DONE.
  - If the wait counter reaches TIMEOUT_CYCLES without ack: go to DONE with cause 3. An ack arriving later is ignored.
- Store lanes, with o=addr[1:0]:
  - SB: wstrb = 4'b0001<<o, wdata = {4{sd[7:0]}}.
  - SH: wstrb = 4'b0011<<o, wdata = {2{sd[15:0]}}.
  - SW: wstrb = 4'b1111, wdata = sd.
  - Loads drive wstrb = 0.
- Load extract: shifted = rdata >> (8*o).
  - LB/LBU: shifted[7:0], sign- or zero-extended.
  - LH/LHU: shifted[15:0], sign- or zero-extended.
  - LW: the full word.
- DONE lasts one cycle.
  - `done`=1 always.
  - `wb_valid`=1 for a successful load with rd != 0.
  - `exc_valid`=1 on a fault.
  - Next state is IDLE.

## Timing
- Reset values:
  - state IDLE, `req_ready`=1.
  - `mem_req`, `mem_we`, `done`, `wb_valid`, `exc_valid` = 0.
  - `mem_addr`, `mem_wstrb`, `mem_wdata`, `wb_rd`, `wb_data`, `exc_cause`, `exc_addr` = 0.
  - Timeout counter = 0.
- Accept at edge T.
  - `mem_req` is high during cycle T+1.
  - Ack in T+1 gives `done` and `wb_data` in T+2. Minimum latency is 2 cycles; each extra wait cycle adds 1.
- Fault detected at accept: `done`/`exc_valid` in T+1. `mem_req` is never asserted.
- `wb_*` and `exc_*` are registered and valid only in the DONE cycle. `wb_data` holds its value afterward.
- Next request is accepted in the cycle after DONE, so there is no back-to-back overlap.
- Timeout:
  - The counter increments each REQ cycle without ack.
  - Cycle TIMEOUT_CYCLES of REQ without ack leads to DONE next.
  - An ack in that same cycle wins: the access completes normally.
- Reset while in REQ: `mem_req` drops at the next edge. An ack in the following cycle has no effect; no `done` pulse.
- `req_valid` in a non-IDLE state is ignored; the requester must hold it.

## Test plan
- LW at addr 0x100, mem_ack in the first REQ cycle, rdata 0xDEADBEEF, rd=5 -> mem_addr 0x100, wstrb 0; `done` and `wb_valid` in T+2, wb_data 0xDEADBEEF, wb_rd 5.
- LB at 0x103 and LBU at 0x103, rdata 0x80FF7F01 -> wb_data 0xFFFFFF80 and 0x00000080 respectively.
- SB at 0x202, sd 0x000000AB, ack after 3 wait cycles -> mem_addr 0x200, wstrb 0100, wdata 0xABABABAB, mem_we=1 stable for 4 cycles, `done` next cycle, wb_valid 0.
- LH at 0x101 -> no `mem_req`; exc_valid and done in T+1, exc_cause 0, exc_addr 0x101. A store with funct3=011 -> exc_cause 2.
- TIMEOUT_CYCLES=4, no ack -> mem_req high 4 cycles, then done + exc_cause 3. A late ack is ignored and the next request is accepted normally.
- Reset asserted in the second REQ cycle -> mem_req 0 after the edge, req_ready 1. A subsequent ack produces no `done`/`wb_valid`.
